// File: rtl/signed_divider_seq.sv
// Sequential signed divider: restoring division on operand magnitudes, one quotient bit
// per enabled cycle, with the sign fix applied as the last step's result is registered.
module signed_divider_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow,
    output logic [1:0]   dbg_state_o
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   acc_q, acc_d;     // dividend magnitude shifts out MSB-first, quotient bits shift in
    logic [N:0]     rem_q, rem_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic [N-1:0]   dvd_q, dvd_d;
    logic           q_neg_q, q_neg_d;
    logic           r_neg_q, r_neg_d;
    logic           dz_q, dz_d;
    logic           ov_q, ov_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [N-1:0]   rmd_q, rmd_d;
    logic           dz_out_q, dz_out_d;
    logic           ov_out_q, ov_out_d;

    logic [N:0]     shifted;
    logic [N:0]     diff;
    logic [N-1:0]   dvd_mag;
    logic [N-1:0]   dvs_mag;

    // An unsigned N-bit magnitude holds 2^(N-1) exactly, so the most negative operand needs no special path.
    assign dvd_mag = dividend[N-1] ? (~dividend + {{(N-1){1'b0}}, 1'b1}) : dividend;
    assign dvs_mag = divisor[N-1]  ? (~divisor  + {{(N-1){1'b0}}, 1'b1}) : divisor;
    assign shifted = {rem_q[N-1:0], acc_q[N-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        dvd_d    = dvd_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        dz_d     = dz_q;
        ov_d     = ov_q;
        quo_d    = quo_q;
        rmd_d    = rmd_q;
        dz_out_d = dz_out_q;
        ov_out_d = ov_out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = dvd_mag;
                    dvs_d   = dvs_mag;
                    dvd_d   = dividend;
                    rem_d   = '0;
                    cnt_d   = '0;
                    q_neg_d = dividend[N-1] ^ divisor[N-1];
                    r_neg_d = dividend[N-1];
                    dz_d    = (divisor == '0);
                    ov_d    = (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (diff[N]) begin
                    rem_d = shifted;
                    acc_d = {acc_q[N-2:0], 1'b0};
                end else begin
                    rem_d = diff;
                    acc_d = {acc_q[N-2:0], 1'b1};
                end
                cnt_d = cnt_q + CW'(1);
                // Results are registered on the final step so they are valid throughout the done cycle.
                if (cnt_q == CW'(N - 1)) begin
                    state_d  = S_DONE;
                    quo_d    = dz_q ? '1 : (q_neg_q ? -acc_d : acc_d);
                    rmd_d    = dz_q ? dvd_q : (r_neg_q ? -rem_d[N-1:0] : rem_d[N-1:0]);
                    dz_out_d = dz_q;
                    ov_out_d = ov_q;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            dvd_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            dz_q     <= 1'b0;
            ov_q     <= 1'b0;
            quo_q    <= '0;
            rmd_q    <= '0;
            dz_out_q <= 1'b0;
            ov_out_q <= 1'b0;
        end else if (en) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            dvd_q    <= dvd_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            dz_q     <= dz_d;
            ov_q     <= ov_d;
            quo_q    <= quo_d;
            rmd_q    <= rmd_d;
            dz_out_q <= dz_out_d;
            ov_out_q <= ov_out_d;
        end
    end

    assign busy        = (state_q == S_CALC) || (state_q == S_DONE);
    assign done        = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dz_out_q;
    assign overflow    = ov_out_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_signed_divider_seq.sv
// Directed bench for signed_divider_seq (N=32): hand-computed vectors, stall, reset-abort
// and start-while-busy scenarios, plus a short random pass against truncating division.
module tb_signed_divider_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero, overflow;
    logic [31:0] quotient, remainder;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad = 0;

    signed_divider_seq #(.N(32)) dut (
        .clk(clk), .reset(reset), .en(en), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Start in the current cycle (cycle 0), expect done in cycle 33 with the given results.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic edz, input logic eov);
        int cyc;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        check({tag, " busy1"}, {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, " latency"}, cyc, 32'd33);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " flags"}, {30'd0, div_by_zero, overflow}, {30'd0, edz, eov});
        tick();
        check({tag, " done_width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int done_cnt;
        int done_cyc;
        int busy_late;
        logic [31:0] ra, rb, req, rer;

        tick();
        tick();
        reset = 1'b0;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst quotient", quotient, 32'd0);
        check("rst remainder", remainder, 32'd0);
        check("rst flags", {30'd0, div_by_zero, overflow}, 32'd0);
        check("rst state", {30'd0, dbg_state}, 32'd0);

        run_div("100/7",     32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0);
        run_div("-100/7",    32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 1'b0);
        run_div("100/-7",    32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 1'b0);
        run_div("-100/-7",   32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 1'b0);
        run_div("5/0",       32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1'b0);
        run_div("-5/0",      32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1, 1'b0);
        run_div("min/-1",    32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 1'b1);
        run_div("min/1",     32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0, 1'b0);
        run_div("max/-1",    32'h7FFFFFFF,   32'hFFFFFFFF,   32'h80000001,   32'd0,          1'b0, 1'b0);
        run_div("min/max",   32'h80000000,   32'h7FFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 1'b0);
        run_div("7/min",     32'd7,          32'h80000000,   32'd0,          32'd7,          1'b0, 1'b0);
        run_div("min/min",   32'h80000000,   32'h80000000,   32'd1,          32'd0,          1'b0, 1'b0);
        run_div("0/5",       32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 1'b0);
        run_div("max/2",     32'h7FFFFFFF,   32'd2,          32'h3FFFFFFF,   32'd1,          1'b0, 1'b0);

        // 1000/3 with an ignored second start at cycle 5 and en low for cycles 10-14.
        done_cnt = 0;
        done_cyc = -1;
        for (int c = 0; c < 45; c++) begin
            start    = (c == 0) || (c == 5);
            dividend = (c == 5) ? 32'd9 : 32'd1000;
            divisor  = (c == 5) ? 32'd2 : 32'd3;
            en       = !(c >= 10 && c <= 14);
            tick();
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c + 1;
            end
        end
        start = 1'b0;
        en = 1'b1;
        check("stall done_count", done_cnt, 32'd1);
        check("stall done_cycle", done_cyc, 32'd38);
        check("stall quotient", quotient, 32'd333);
        check("stall remainder", remainder, 32'd1);

        // en low in DONE stretches done; a start during done is ignored.
        done_cnt = 0;
        done_cyc = -1;
        busy_late = 0;
        for (int c = 0; c < 40; c++) begin
            start    = (c == 0) || (c == 36);
            dividend = (c == 36) ? 32'd9 : 32'd100;
            divisor  = (c == 36) ? 32'd2 : 32'd7;
            en       = !(c >= 33 && c <= 35);
            tick();
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c + 1;
            end
            if (c + 1 >= 37 && busy !== 1'b0) busy_late++;
        end
        start = 1'b0;
        en = 1'b1;
        check("hold done_count", done_cnt, 32'd4);
        check("hold done_cycle", done_cyc, 32'd33);
        check("hold busy_after", busy_late, 32'd0);
        check("hold quotient", quotient, 32'd14);
        check("hold remainder", remainder, 32'd2);

        // Reset mid-CALC aborts the operation and clears the outputs.
        done_cnt = 0;
        for (int c = 0; c <= 12; c++) begin
            start    = (c == 0);
            dividend = 32'd77;
            divisor  = 32'd5;
            reset    = (c == 12);
            tick();
            if (done === 1'b1) done_cnt++;
        end
        start = 1'b0;
        reset = 1'b0;
        check("abort done_count", done_cnt, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort quotient", quotient, 32'd0);
        check("abort remainder", remainder, 32'd0);
        check("abort flags", {30'd0, div_by_zero, overflow}, 32'd0);
        run_div("77/5", 32'd77, 32'd5, 32'd15, 32'd2, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd1;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'h80000000;
                3: rb = 32'h7FFFFFFF;
                default: rb = $urandom >> $urandom_range(0, 28);
            endcase
            if (i == 0) ra = 32'h80000000;
            if (i == 1) ra = 32'h7FFFFFFF;
            if (rb == 32'd0 || (ra == 32'h80000000 && rb == 32'hFFFFFFFF)) rb = 32'd3;
            req = $signed(ra) / $signed(rb);
            rer = $signed(ra) % $signed(rb);
            run_div($sformatf("rand%0d", i), ra, rb, req, rer, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/signed_divider_seq.md
SIGNED_DIVIDER_SEQ -- requirements
Module: signed_divider_seq

Interface
REQ-001 Parameter: N, default 32, operand width in bits (N >= 4).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 en  input  1  global stall control; when 0, all internal state and outputs hold.
REQ-005 start  input  1  request pulse; sampled only in IDLE with en=1.
REQ-006 dividend  input  N  signed two's-complement dividend, captured when start is accepted.
REQ-007 divisor  input  N  signed two's-complement divisor, captured when start is accepted.
REQ-008 busy  output  1  high from the cycle after start acceptance through the done cycle inclusive.
REQ-009 done  output  1  one-cycle result-valid strobe, stretched only by en=0.
REQ-010 quotient  output  N  signed quotient, registered.
REQ-011 remainder  output  N  signed remainder, registered.
REQ-012 div_by_zero  output  1  set with done when the captured divisor = 0.
REQ-013 overflow  output  1  set with done when dividend = -2^(N-1) and divisor = -1.

Function
REQ-014 States: IDLE, CALC, DONE; encoded registers only, no latches.
REQ-015 IDLE: start=1 and en=1 -> capture operands, |dividend|, |divisor|, and both signs; clear iteration counter; go to CALC.
REQ-016 CALC: one restoring-division step per en=1 cycle: shift partial remainder (N+1 bits) left by one, bringing in the next dividend magnitude bit MSB-first; subtract |divisor|; if the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
REQ-017 CALC lasts exactly N en=1 cycles (counter 0..N-1), then goes to DONE.
REQ-018 DONE: apply the sign fix, load quotient/remainder/flags into the output registers, assert done for that cycle, then go to IDLE.
REQ-019 Latency: start accepted in cycle 0 -> done=1 in cycle N+1 with en held 1 (N=32: cycle 33); each en=0 cycle adds one cycle.
REQ-020 Sign rules: truncation toward zero; quotient negated iff operand signs differ; remainder takes the dividend's sign; |remainder| < |divisor|.
REQ-021 Divide by zero: same latency; quotient = all ones, remainder = dividend, div_by_zero=1, overflow=0.
REQ-022 Overflow case (-2^(N-1) / -1): quotient = -2^(N-1) (wrapped), remainder = 0, overflow=1, div_by_zero=0.
REQ-023 Magnitude of -2^(N-1) is handled in N+1-bit arithmetic; no intermediate truncation.
REQ-024 start while busy (CALC/DONE) is ignored; the captured operands are not disturbed.
REQ-025 start in the same cycle that done is high is ignored; the earliest acceptance is the next cycle (IDLE).
REQ-026 quotient, remainder, and the flags hold their values from done until the next done; they are not cleared by a new start.
REQ-027 en=0 in DONE: done stays high and state holds until the first en=1 cycle, after which the state is IDLE.
REQ-028 busy = (state == CALC) or (state == DONE); done = (state == DONE).

Reset
REQ-029 reset=1 at a clock edge -> state IDLE; busy, done, quotient, remainder, div_by_zero, overflow, and the counter all 0.
REQ-030 reset takes priority over en and start, including mid-CALC and in DONE; an aborted operation produces no done.
REQ-031 First start may be accepted in the first cycle after reset deasserts.

Verification (N=32, en=1 unless stated)
REQ-032 100 / 7 -> done in cycle 33; quotient=14, remainder=2, flags 0.
REQ-033 -100 / 7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); 100 / -7 -> quotient=-14, remainder=2.
REQ-034 5 / 0 -> div_by_zero=1, quotient=0xFFFFFFFF, remainder=5, done in cycle 33; 0x80000000 / 0xFFFFFFFF -> overflow=1, quotient=0x80000000, remainder=0.
REQ-035 Start 1000/3; second start 9/2 at cycle 5; en=0 for cycles 10-14 -> single done at cycle 38, quotient=333, remainder=1; 9/2 never computed.
REQ-036 Start 77/5; reset at cycle 12 -> all outputs 0, no done; start 77/5 after reset -> quotient=15, remainder=2 after 33 cycles.
REQ-037 Random signed pairs (incl. ±2^31-boundary values, divisor ±1) checked against truncating reference division; done width exactly 1 cycle.
